// File: rtl/ex_writeback_arbiter_pkg.sv
// Shared defaults and helpers for the execution writeback arbiter.
package ex_writeback_arbiter_pkg;

  // Default configuration: three channels, two-entry FIFOs, 32-bit results,
  // 64-entry rename register file.
  localparam int EXWB_NUM_CH_DEF = 3;
  localparam int EXWB_DEPTH_DEF  = 2;
  localparam int DATA_LEN_DEF    = 32;
  localparam int RRF_SEL_DEF     = 6;

  // Width of one queued entry: {result, tag, rrf_we, rob_we}.
  function automatic int exwb_entry_w(input int data_len, input int rrf_sel);
    return data_len + rrf_sel + 2;
  endfunction

  // True when v is a nonzero power of two; FIFO pointers rely on natural wrap.
  function automatic bit exwb_is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/ex_result_fifo.sv
// Single-channel result FIFO with synchronous flush; storage is not reset.
module ex_result_fifo
  import ex_writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = EXWB_DEPTH_DEF,
  parameter int W     = 40
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               din_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [W-1:0]               head_o
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  // Control state: pointers and count; flush wins over push and pop.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + PW'(1);
      if (pop_i)  rd_ptr <= rd_ptr + PW'(1);
      if (push_i && !pop_i)      count <= count + (PW+1)'(1);
      else if (pop_i && !push_i) count <= count - (PW+1)'(1);
    end
  end

  // Data storage: written on accepted push, never reset.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem[wr_ptr] <= din_i;
  end

  assign count_o = count;
  assign head_o  = mem[rd_ptr];

endmodule

// File: rtl/ex_writeback_arbiter.sv
// Per-channel result FIFOs drained round-robin onto one ROB/RRF writeback port.
module ex_writeback_arbiter
  import ex_writeback_arbiter_pkg::*;
#(
  parameter int NUM_CH   = EXWB_NUM_CH_DEF,
  parameter int DEPTH    = EXWB_DEPTH_DEF,
  parameter int DATA_LEN = DATA_LEN_DEF,
  parameter int RRF_SEL  = RRF_SEL_DEF,
  parameter int CH_SEL   = $clog2(NUM_CH)
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic                                flush_i,
  input  logic [NUM_CH-1:0]                   ch_valid_i,
  output logic [NUM_CH-1:0]                   ch_ready_o,
  input  logic [NUM_CH*DATA_LEN-1:0]          ch_result_i,
  input  logic [NUM_CH*RRF_SEL-1:0]           ch_rrf_tag_i,
  input  logic [NUM_CH-1:0]                   ch_rrf_we_i,
  input  logic [NUM_CH-1:0]                   ch_rob_we_i,
  output logic                                wb_valid_o,
  input  logic                                wb_ready_i,
  output logic [DATA_LEN-1:0]                 wb_result_o,
  output logic [RRF_SEL-1:0]                  wb_rrf_tag_o,
  output logic                                wb_rrf_we_o,
  output logic                                wb_rob_we_o,
  output logic [CH_SEL-1:0]                   wb_ch_o,
  output logic [NUM_CH*($clog2(DEPTH)+1)-1:0] occupancy_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = exwb_entry_w(DATA_LEN, RRF_SEL);

  if (!exwb_is_pow2(DEPTH) || DEPTH < 2) begin : g_depth_check
    $error("ex_writeback_arbiter: DEPTH must be a power of two >= 2");
  end

  logic [CW-1:0]     count [NUM_CH];
  logic [EW-1:0]     head  [NUM_CH];
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [CH_SEL-1:0] rr_ptr;
  logic [CH_SEL-1:0] grant;
  logic              xfer;
  logic [EW-1:0]     wb_entry;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign ch_ready_o[c] = (count[c] != CW'(DEPTH));
    assign req[c]        = (count[c] != '0);
    assign push[c]       = ch_valid_i[c] & ch_ready_o[c];
    assign pop[c]        = xfer & (grant == CH_SEL'(c));
    assign occupancy_o[c*CW +: CW] = count[c];

    ex_result_fifo #(
      .DEPTH (DEPTH),
      .W     (EW)
    ) u_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .flush_i   (flush_i),
      .push_i    (push[c]),
      .pop_i     (pop[c]),
      .din_i     ({ch_result_i[c*DATA_LEN +: DATA_LEN],
                   ch_rrf_tag_i[c*RRF_SEL +: RRF_SEL],
                   ch_rrf_we_i[c], ch_rob_we_i[c]}),
      .count_o   (count[c]),
      .head_o    (head[c])
    );
  end

  // Round-robin grant: first requester at or after rr_ptr, wrapping upward.
  always_comb begin
    int  idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    grant = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && req[idx]) begin
        found = 1'b1;
        grant = CH_SEL'(idx);
      end
    end
  end

  assign wb_valid_o = |req;
  assign xfer       = wb_valid_o & wb_ready_i & ~flush_i;

  // Round-robin pointer: moves past the granted channel only on a transfer.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_ptr <= '0;
    end else if (flush_i) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= (grant == CH_SEL'(NUM_CH - 1)) ? '0 : grant + CH_SEL'(1);
    end
  end

  assign wb_entry     = head[grant];
  assign wb_result_o  = wb_entry[EW-1 -: DATA_LEN];
  assign wb_rrf_tag_o = wb_entry[2 +: RRF_SEL];
  assign wb_rrf_we_o  = wb_entry[1] & wb_valid_o;
  assign wb_rob_we_o  = wb_entry[0] & wb_valid_o;
  assign wb_ch_o      = grant;

endmodule
